sine_frame_decoder: RTL and testbench
=====================================

SINE_FRAME_DECODER -- requirements
Module: sine_frame_decoder

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-003 SHALL have port En, input, 1: enable; low clears the frame state synchronously.
REQ-004 SHALL have port Vld, input, 1: frame marker; a one-cycle pulse precedes every 6-chunk frame.
REQ-005 SHALL have port Ain, input, 2: serialized phase-address chunk, LSB chunk first.
REQ-006 SHALL have port ISin, input, 1: invert-sign flag for the frame.
REQ-007 SHALL have port Dout, output, 12: signed two's-complement sine sample, registered.
REQ-008 SHALL have port Dvld, output, 1: one-cycle strobe, high while the Dout update is first presented.
REQ-009 SHALL have port Perr, output, 1: one-cycle strobe, coincident with Dvld, marking an illegal quadrant code.

Function
REQ-010 SHALL define a frame as a Vld cycle, then six consecutive chunk cycles C0..C5, with Ain in Ck carrying address bits [2k+1:2k].
REQ-011 SHALL sample ISin in the C5 cycle only.
REQ-012 SHALL implement a frame FSM with states IDLE and SHIFT (chunk counter 0..5); Vld moves IDLE->SHIFT; C5 returns to IDLE and launches lookup.
REQ-013 SHALL treat Vld asserted during SHIFT as an abort: discard partial address, restart at C0 next cycle, no Dvld for the aborted frame.
REQ-014 SHALL accept back-to-back frames, where a Vld in the cycle after C5 is legal, giving one Dvld per 7 cycles.
REQ-015 SHALL, when En is low, force IDLE, clear the shift register and pipeline valids, and hold Dout.
REQ-016 SHALL decode the 12-bit address A as follows: A[11:10]=00 gives idx=A[9:0]; 11 gives idx=1023-A[9:0] (mirror); 01 or 10 mirror iff A[11] and assert Perr with that sample's Dvld.
REQ-017 SHALL read a quarter-wave ROM, 1024 x 11-bit unsigned, mag(i)=round(2047*sin(pi*(2i+1)/4096)), with a registered output (1 cycle).
REQ-018 SHALL apply sign in a registered stage: Dout=ISin ? -mag : +mag, 12-bit, range -2047..+2047, no saturation needed.
REQ-019 SHALL produce Dout/Dvld exactly 2 cycles after the C5 cycle, so Dvld is high in cycle C5+2.
REQ-020 SHALL ignore Ain and ISin outside SHIFT.

Reset
REQ-021 SHALL, on rst high, set state IDLE, counter 0, shift register 0, pipeline valids 0, Dout=0, Dvld=0, Perr=0, independent of clk.
REQ-022 SHALL discard any in-flight frame or lookup on reset mid-operation; the first Dvld after release requires a complete new frame.

Structure
REQ-023 SHALL place ADDR_W=12, IDX_W=10, MAG_W=11, OUT_W=12, CHUNKS=6, and the quadrant code constants in shared package nco_pkg.
REQ-024 SHALL instantiate the ROM as sub-module sine_qrom (10-bit address in, registered 11-bit magnitude out, clk only, no reset).
REQ-025 SHALL keep the FSM, deserializer, mirror logic and sign stage in sine_frame_decoder.

Verification
REQ-026 SHALL cover: A=0x000, ISin=0 (chunks 0,0,0,0,0,0) -> Dout=+2, Dvld at C5+2, Perr=0.
REQ-027 SHALL cover: A=0x3FF, ISin=0 (chunks 3,3,3,3,3,0) -> Dout=+2047.
REQ-028 SHALL cover: A=0xC00, ISin=1 (chunks 0,0,0,0,0,3) -> idx=1023, Dout=-2047, Perr=0.
REQ-029 SHALL cover: A=0x400 (quadrant code 01) -> Dout=+2, Perr=1 with Dvld.
REQ-030 SHALL cover: Vld re-asserted at C3, then a full frame with A=0x3FF -> exactly one Dvld with Dout=+2047.
REQ-031 SHALL cover: rst pulse at C2, or En low at C4 -> no Dvld and Dout unchanged; continuous 7-cycle frames afterward -> Dvld every 7 cycles.

Source files
------------

// File: rtl/nco_pkg.sv
//------------------------------------------------------------------------------
// Module  : nco_pkg
// Brief   : Shared widths, quadrant codes, frame FSM states and the
//           quarter-wave sine magnitude function for the frame decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package nco_pkg;

  localparam int ADDR_W = 12;
  localparam int IDX_W  = 10;
  localparam int MAG_W  = 11;
  localparam int OUT_W  = 12;
  localparam int CHUNKS = 6;
  localparam int CNT_W  = 3;

  // Quadrant codes carried in A[11:10]
  localparam logic [1:0] QUAD_POS    = 2'b00;
  localparam logic [1:0] QUAD_LO_BAD = 2'b01;
  localparam logic [1:0] QUAD_HI_BAD = 2'b10;
  localparam logic [1:0] QUAD_NEG    = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } frame_state_e;

  // round(pi * 2^30)
  localparam longint PI_Q30 = 64'sd3373259426;

  // mag(i) = round(2047 * sin(pi*(2i+1)/4096)), evaluated at elaboration
  // with a Q30 Taylor series (terms up to x^15, error far below one LSB).
  function automatic logic [MAG_W-1:0] qrom_mag(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint res;
    x    = (PI_Q30 * longint'(2 * idx + 1) + 64'sd2048) >>> 12;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 7; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    res = (sum * 64'sd2047 + 64'sd536870912) >>> 30;
    return MAG_W'(res);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sine_qrom.sv
//------------------------------------------------------------------------------
// Module  : sine_qrom
// Brief   : 1024 x 11-bit quarter-wave sine magnitude ROM, registered output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sine_qrom
  import nco_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] addr_i,
  output logic [MAG_W-1:0] mag_o
);

  logic [MAG_W-1:0] rom [1 << IDX_W];
  logic [MAG_W-1:0] mag_q;

  // Table contents are constants computed at elaboration
  for (genvar gi = 0; gi < (1 << IDX_W); gi++) begin : g_rom_entry
    localparam logic [MAG_W-1:0] MAG = qrom_mag(gi);
    assign rom[gi] = MAG;
  end

  // Synchronous read, no reset on the data path
  always_ff @(posedge clk) begin
    mag_q <= rom[addr_i];
  end

  assign mag_o = mag_q;

endmodule

`default_nettype wire

// File: rtl/sine_frame_decoder.sv
//------------------------------------------------------------------------------
// Module  : sine_frame_decoder
// Brief   : Deserializes 6 x 2-bit phase chunks per frame, folds the quadrant
//           onto a quarter-wave ROM, applies sign and presents a registered
//           12-bit sine sample two cycles after the last chunk.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sine_frame_decoder
  import nco_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             Vld,
  input  logic [1:0]       Ain,
  input  logic             ISin,
  output logic [OUT_W-1:0] Dout,
  output logic             Dvld,
  output logic             Perr
);

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  frame_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-3:0]     shreg_q;
  logic [ADDR_W-3:0]     shreg_d;

  logic [ADDR_W-1:0]     addr;
  logic [1:0]            quad;
  logic                  mirror;
  logic                  bad_quad;
  logic [IDX_W-1:0]      idx;
  logic                  launch;

  logic                  v1_q;
  logic                  sign_q;
  logic                  perr1_q;
  logic [MAG_W-1:0]      mag;
  logic [OUT_W-1:0]      mag_ext;
  logic [OUT_W-1:0]      dout_q;
  logic                  dvld_q;
  logic                  perr_q;

  // Chunks enter at the top so C0 ends up in the least significant bits;
  // the C5 chunk is taken straight from Ain to complete the address.
  assign shreg_d  = {Ain, shreg_q[ADDR_W-3:2]};
  assign addr     = {Ain, shreg_q};
  assign quad     = addr[ADDR_W-1:ADDR_W-2];
  assign mirror   = (quad == QUAD_NEG) || (quad == QUAD_HI_BAD);
  assign bad_quad = (quad == QUAD_LO_BAD) || (quad == QUAD_HI_BAD);
  // 1023 - x is the bitwise complement for a 10-bit index
  assign idx      = mirror ? ~addr[IDX_W-1:0] : addr[IDX_W-1:0];
  // A Vld in the C5 cycle is an abort, so it blocks the launch
  assign launch   = En && !Vld && (state_q == ST_SHIFT) && (cnt_q == LAST_CHUNK);

  // Frame FSM and chunk deserializer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (!En) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Vld) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (Vld) begin
            cnt_q   <= '0;
            shreg_q <= '0;
          end else if (cnt_q == LAST_CHUNK) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            shreg_q <= shreg_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          shreg_q <= '0;
        end
      endcase
    end
  end

  // The ROM registers the folded index at the end of C5
  sine_qrom u_qrom (
    .clk    (clk),
    .addr_i (idx),
    .mag_o  (mag)
  );

  assign mag_ext = {1'b0, mag};

  // Lookup valid, sign and error flags travel alongside the ROM read,
  // then the sign stage presents the sample in cycle C5+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign_q  <= 1'b0;
      perr1_q <= 1'b0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else if (!En) begin
      v1_q    <= 1'b0;
      dvld_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      v1_q   <= launch;
      dvld_q <= v1_q;
      perr_q <= v1_q && perr1_q;
      if (launch) begin
        sign_q  <= ISin;
        perr1_q <= bad_quad;
      end
      if (v1_q) begin
        dout_q <= sign_q ? (~mag_ext + OUT_W'(1)) : mag_ext;
      end
    end
  end

  assign Dout = dout_q;
  assign Dvld = dvld_q;
  assign Perr = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_sine_frame_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_sine_frame_decoder
// Brief   : Directed self-checking bench for sine_frame_decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sine_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        En;
  logic        Vld;
  logic [1:0]  Ain;
  logic        ISin;
  logic [11:0] Dout;
  logic        Dvld;
  logic        Perr;

  int n_vec     = 0;
  int n_err     = 0;
  int dvld_seen = 0;
  int base;

  logic [11:0] ca   [4] = '{12'h3FF, 12'h000, 12'hC00, 12'h200};
  logic        cs   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [11:0] cexp [4] = '{12'h7FF, 12'h002, 12'h801, 12'h5A9};

  always #5 clk = ~clk;

  sine_frame_decoder dut (
    .clk  (clk),
    .rst  (rst),
    .En   (En),
    .Vld  (Vld),
    .Ain  (Ain),
    .ISin (ISin),
    .Dout (Dout),
    .Dvld (Dvld),
    .Perr (Perr)
  );

  // Count strobes away from the active edge
  always @(negedge clk) begin
    if (Dvld === 1'b1) dvld_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Vld  = 1'b0;
    Ain  = 2'b01;
    ISin = 1'b1;
  endtask

  task automatic send_vld();
    Vld  = 1'b1;
    Ain  = 2'b10;
    ISin = 1'b1;
    step();
    Vld  = 1'b0;
  endtask

  // ISin is the opposite of the frame value except in C5
  task automatic send_chunk(input logic [11:0] a, input logic isn, input int k);
    Vld  = 1'b0;
    Ain  = a[2*k +: 2];
    ISin = (k == 5) ? isn : ~isn;
    step();
  endtask

  task automatic run_frame(input string tag, input logic [11:0] a, input logic isn,
                           input logic [11:0] exp_d, input logic exp_p);
    send_vld();
    for (int k = 0; k < 6; k++) send_chunk(a, isn, k);
    idle_in();
    check({tag, "_dvld_c5p1"}, 32'(Dvld), 32'd0);
    step();
    check({tag, "_dvld_c5p2"}, 32'(Dvld), 32'd1);
    check({tag, "_dout"}, 32'(Dout), 32'(exp_d));
    check({tag, "_perr"}, 32'(Perr), 32'(exp_p));
    step();
    check({tag, "_strobe_end"}, 32'(Dvld), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; En = 1'b0; Vld = 1'b0; Ain = 2'b00; ISin = 1'b0;
    #2;
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_dvld", 32'(Dvld), 32'd0);
    check("rst_perr", 32'(Perr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; En = 1'b1;
    idle_in();
    step();
    check("idle_no_dvld", 32'(dvld_seen), 32'd0);

    run_frame("a000",      12'h000, 1'b0, 12'h002, 1'b0);
    run_frame("a3ff",      12'h3FF, 1'b0, 12'h7FF, 1'b0);
    run_frame("ac00_neg",  12'hC00, 1'b1, 12'h801, 1'b0);
    run_frame("a400_perr", 12'h400, 1'b0, 12'h002, 1'b1);
    run_frame("a001",      12'h001, 1'b0, 12'h005, 1'b0);
    run_frame("a7fe_perr", 12'h7FE, 1'b0, 12'h7FF, 1'b1);
    run_frame("a800_perr", 12'h800, 1'b1, 12'h801, 1'b1);
    run_frame("afff_neg",  12'hFFF, 1'b1, 12'hFFE, 1'b0);
    run_frame("a200",      12'h200, 1'b0, 12'h5A9, 1'b0);
    run_frame("adff_neg",  12'hDFF, 1'b1, 12'hA57, 1'b0);

    // Abort at C3, then a complete frame
    base = dvld_seen;
    send_vld();
    for (int k = 0; k < 3; k++) send_chunk(12'hFFF, 1'b1, k);
    send_vld();
    for (int k = 0; k < 6; k++) send_chunk(12'h3FF, 1'b0, k);
    idle_in();
    repeat (4) step();
    check("abort_dvld_count", 32'(dvld_seen - base), 32'd1);
    check("abort_dout", 32'(Dout), 32'h7FF);

    // En low in C4: frame dropped, Dout held
    base = dvld_seen;
    send_vld();
    for (int k = 0; k < 4; k++) send_chunk(12'h000, 1'b0, k);
    En = 1'b0;
    send_chunk(12'h000, 1'b0, 4);
    En = 1'b1;
    send_chunk(12'h000, 1'b0, 5);
    idle_in();
    repeat (4) step();
    check("en_low_dvld_count", 32'(dvld_seen - base), 32'd0);
    check("en_low_dout_hold", 32'(Dout), 32'h7FF);

    // Asynchronous reset pulse during C2
    base = dvld_seen;
    send_vld();
    for (int k = 0; k < 2; k++) send_chunk(12'h200, 1'b0, k);
    Ain = 2'b00; ISin = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_c2_async_dout", 32'(Dout), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 3; k < 6; k++) send_chunk(12'h200, 1'b0, k);
    idle_in();
    repeat (4) step();
    check("rst_c2_dvld_count", 32'(dvld_seen - base), 32'd0);
    check("rst_c2_dout", 32'(Dout), 32'd0);

    // Reset while the lookup is in flight (cycle C5+1)
    base = dvld_seen;
    send_vld();
    for (int k = 0; k < 6; k++) send_chunk(12'h3FF, 1'b0, k);
    idle_in();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();
    check("rst_inflight_dvld_count", 32'(dvld_seen - base), 32'd0);
    check("rst_inflight_dout", 32'(Dout), 32'd0);

    // Back-to-back 7-cycle frames
    base = dvld_seen;
    for (int f = 0; f < 4; f++) begin
      send_vld();
      if (f > 0) begin
        check($sformatf("cont%0d_dvld", f - 1), 32'(Dvld), 32'd1);
        check($sformatf("cont%0d_dout", f - 1), 32'(Dout), 32'(cexp[f-1]));
      end
      for (int k = 0; k < 6; k++) send_chunk(ca[f], cs[f], k);
    end
    idle_in();
    check("cont3_dvld_c5p1", 32'(Dvld), 32'd0);
    step();
    check("cont3_dvld", 32'(Dvld), 32'd1);
    check("cont3_dout", 32'(Dout), 32'(cexp[3]));
    step();
    check("cont_dvld_count", 32'(dvld_seen - base), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
